// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the fetch-PC generator.
//   state_e     : fetch FSM state (boot / run / halt)
//   align_bits  : number of low PC bits forced to zero by instruction alignment
package pc_gen_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_e;

  function automatic int align_bits(input int ilen_bytes);
    return $clog2(ilen_bytes);
  endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// pc_redirect_latch: holds one redirect that arrived while the fetch request
// was stuck in handshake, so the PC stays stable until IMEM accepts.
// Ports:
//   clk, reset       clock / async active-low reset
//   hold_i           request presented but not accepted this cycle
//   apply_i          a redirect is being written into the PC; drop the pending one
//   trap_valid_i/trap_target_i, br_valid_i/br_target_i  incoming redirects
//   pend_valid_o     a redirect is pending
//   pend_target_o    pending redirect target (raw, unaligned)
module pc_redirect_latch #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            hold_i,
  input  logic            apply_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_target_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            pend_valid_o,
  output logic [XLEN-1:0] pend_target_o
);

  logic            pend_valid_q, pend_valid_d;
  logic            pend_is_trap_q, pend_is_trap_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  // A trap always overwrites; a branch never displaces a pending trap.
  always_comb begin
    pend_valid_d   = pend_valid_q;
    pend_is_trap_d = pend_is_trap_q;
    pend_target_d  = pend_target_q;
    if (apply_i) begin
      pend_valid_d   = 1'b0;
      pend_is_trap_d = 1'b0;
    end else if (hold_i && trap_valid_i) begin
      pend_valid_d   = 1'b1;
      pend_is_trap_d = 1'b1;
      pend_target_d  = trap_target_i;
    end else if (hold_i && br_valid_i && !(pend_valid_q && pend_is_trap_q)) begin
      pend_valid_d   = 1'b1;
      pend_is_trap_d = 1'b0;
      pend_target_d  = br_target_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q   <= 1'b0;
      pend_is_trap_q <= 1'b0;
      pend_target_q  <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_is_trap_q <= pend_is_trap_d;
      pend_target_q  <= pend_target_d;
    end
  end

  assign pend_valid_o  = pend_valid_q;
  assign pend_target_o = pend_target_q;

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-PC generator at the head of IF.
// Holds the fetch PC, offers it to IMEM over valid/ready, steps by
// ILEN_BYTES on accept, applies trap/branch redirects (deferred while the
// request is stalled in handshake) and supports halt/resume.
// Ports:
//   clk, reset                 clock / async active-low reset
//   stall                      suppress fetch requests
//   br_valid/br_target         branch redirect (1 cycle)
//   trap_valid/trap_target     trap redirect (1 cycle, outranks branch)
//   halt_req/resume            enter / leave halt
//   if_req_valid/if_req_ready  fetch handshake; if_req_pc is the address
//   pc_plus                    pc + ILEN_BYTES (wraps)
//   misaligned                 pulse: last applied redirect target was unaligned
//   halted                     FSM is in S_HALT
module pc_gen_unit
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              ILEN_BYTES   = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  input  logic            halt_req,
  input  logic            resume,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            misaligned,
  output logic            halted
);

  localparam int              AB         = align_bits(ILEN_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << AB) - 64'd1);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic            hold, fire;
  logic            sel_vld, apply;
  logic [XLEN-1:0] sel_tgt;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;

  assign if_req_valid = (state_q == S_RUN) && !stall;
  assign hold         = if_req_valid && !if_req_ready;
  assign fire         = if_req_valid && if_req_ready;
  assign pc_plus      = pc_q + XLEN'(ILEN_BYTES);
  assign if_req_pc    = pc_q;
  assign misaligned   = mis_q;
  assign halted       = (state_q == S_HALT);

  // Fresh requests outrank a latched one; trap outranks branch.
  always_comb begin
    sel_vld = 1'b1;
    sel_tgt = '0;
    if (trap_valid)      sel_tgt = trap_target;
    else if (br_valid)   sel_tgt = br_target;
    else if (pend_valid) sel_tgt = pend_target;
    else                 sel_vld = 1'b0;
  end

  // While held the PC must stay put, so redirects only land when hold=0.
  assign apply = sel_vld && !hold;

  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (apply) begin
      pc_d  = sel_tgt & ~ALIGN_MASK;
      mis_d = |(sel_tgt & ALIGN_MASK);
    end else if (fire) begin
      pc_d  = pc_plus;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN:  if (halt_req && !hold) state_d = S_HALT;
      S_HALT: if (resume) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_VECTOR;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
    end
  end

  pc_redirect_latch #(.XLEN(XLEN)) u_latch (
    .clk           (clk),
    .reset         (reset),
    .hold_i        (hold),
    .apply_i       (apply),
    .trap_valid_i  (trap_valid),
    .trap_target_i (trap_target),
    .br_valid_i    (br_valid),
    .br_target_i   (br_target),
    .pend_valid_o  (pend_valid),
    .pend_target_o (pend_target)
  );

endmodule

// File: tb/tb_pc_gen_unit.sv
module tb_pc_gen_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_valid, trap_valid, halt_req, resume, if_req_ready;
  logic [31:0] br_target, trap_target;
  logic        if_req_valid, misaligned, halted;
  logic [31:0] if_req_pc, pc_plus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(.XLEN(32), .ILEN_BYTES(4), .RESET_VECTOR(32'h0)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .trap_valid   (trap_valid),
    .trap_target  (trap_target),
    .halt_req     (halt_req),
    .resume       (resume),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_pc    (if_req_pc),
    .pc_plus      (pc_plus),
    .misaligned   (misaligned),
    .halted       (halted)
  );

  typedef struct {
    logic        stall, rdy, brv, trv, hlt, res;
    logic [31:0] brt, trt;
    logic        e_vld, e_halted, e_mis;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    int          idx;
    logic        vld, halted, mis;
    logic [31:0] pc, plus;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rdy, input logic brv, input logic [31:0] brt,
                              input logic trv, input logic [31:0] trt, input logic hlt, input logic res,
                              input logic e_vld, input logic [31:0] e_pc, input logic e_h, input logic e_m);
    vec_t v;
    v.stall = st; v.rdy = rdy; v.brv = brv; v.brt = brt; v.trv = trv; v.trt = trt;
    v.hlt = hlt; v.res = res; v.e_vld = e_vld; v.e_pc = e_pc; v.e_halted = e_h; v.e_mis = e_m;
    return v;
  endfunction

  task automatic drive_idle();
    stall = 0; br_valid = 0; br_target = '0; trap_valid = 0; trap_target = '0;
    halt_req = 0; resume = 0; if_req_ready = 1;
  endtask

  // Drive at negedge, push expectation, sample 1ns later (well before posedge).
  task automatic run_vec(input int idx, input vec_t v);
    exp_t e, g;
    @(negedge clk);
    stall = v.stall; if_req_ready = v.rdy; br_valid = v.brv; br_target = v.brt;
    trap_valid = v.trv; trap_target = v.trt; halt_req = v.hlt; resume = v.res;
    e.idx = idx; e.vld = v.e_vld; e.pc = v.e_pc; e.halted = v.e_halted; e.mis = v.e_mis;
    e.plus = v.e_pc + 32'd4;
    sb.push_back(e);
    #1;
    g = sb.pop_front();
    check($sformatf("v%0d valid", g.idx), {31'b0, if_req_valid}, {31'b0, g.vld});
    check($sformatf("v%0d pc", g.idx), if_req_pc, g.pc);
    check($sformatf("v%0d pc_plus", g.idx), pc_plus, g.plus);
    check($sformatf("v%0d halted", g.idx), {31'b0, halted}, {31'b0, g.halted});
    check($sformatf("v%0d misaligned", g.idx), {31'b0, misaligned}, {31'b0, g.mis});
  endtask

  initial begin
    drive_idle();
    reset = 0;
    #1;
    check("reset valid", {31'b0, if_req_valid}, 32'd0);
    check("reset pc", if_req_pc, 32'h0);
    check("reset halted", {31'b0, halted}, 32'd0);
    check("reset misaligned", {31'b0, misaligned}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1;

    //        st rdy brv brt          trv trt     hlt res  vld pc            h  m
    // 1: boot then sequential
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  0, 32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h0,        0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h4,        0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h8,        0, 0));
    // 2: branch latched during hold, applied after accept
    tbl.push_back(mk(0, 0, 1, 32'h100,      0, 32'h0,  0, 0,  1, 32'hC,        0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'hC,        0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'hC,        0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h100,      0, 0));
    // 3: pending trap survives a later branch
    tbl.push_back(mk(0, 0, 1, 32'h100,      0, 32'h0,  0, 0,  1, 32'h104,      0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        1, 32'h80, 0, 0,  1, 32'h104,      0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h200,      0, 32'h0,  0, 0,  1, 32'h104,      0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h104,      0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h80,       0, 0));
    // 4: trap beats branch; misaligned branch
    tbl.push_back(mk(0, 1, 1, 32'h100,      1, 32'h80, 0, 0,  1, 32'h84,       0, 0));
    tbl.push_back(mk(0, 1, 1, 32'h103,      0, 32'h0,  0, 0,  1, 32'h80,       0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h100,      0, 1));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h104,      0, 0));
    // stall: no request, redirect applies directly
    tbl.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,  0, 0,  0, 32'h108,      0, 0));
    tbl.push_back(mk(1, 0, 1, 32'h10,       0, 32'h0,  0, 0,  0, 32'h108,      0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h10,       0, 0));
    // 5: halt, redirect in halt, resume (resume wins over halt in HALT)
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  1, 0,  1, 32'h14,       0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  0, 32'h18,       1, 0));
    tbl.push_back(mk(0, 1, 1, 32'h40,       0, 32'h0,  0, 0,  0, 32'h18,       1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  1, 1,  0, 32'h40,       1, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h40,       0, 0));
    // halt_req ignored while held
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  1, 0,  1, 32'h44,       0, 0));
    tbl.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h44,       0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h44,       0, 0));
    // 6: wrap
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0,  1, 32'h48,       0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,  0, 0,  1, 32'h0,        0, 0));
    // set up pending state for the async reset
    tbl.push_back(mk(0, 1, 1, 32'h302,      0, 32'h0,  0, 0,  1, 32'h4,        0, 0));
    tbl.push_back(mk(0, 0, 1, 32'h500,      0, 32'h0,  0, 0,  1, 32'h300,      0, 1));

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // Async reset in the middle of a held request with a branch pending.
    @(negedge clk);
    if_req_ready = 0; br_valid = 0;
    #1;
    check("pre-reset pc held", if_req_pc, 32'h300);
    check("pre-reset pend_valid", {31'b0, u_dut.pend_valid}, 32'd1);
    #1 reset = 0;
    #1;
    check("async reset pc", if_req_pc, 32'h0);
    check("async reset pend_valid", {31'b0, u_dut.pend_valid}, 32'd0);
    check("async reset valid", {31'b0, if_req_valid}, 32'd0);
    check("async reset misaligned", {31'b0, misaligned}, 32'd0);
    check("async reset halted", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #2 reset = 1;
    // After reset the pending 0x500 must not reappear.
    run_vec(100, mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 0));
    run_vec(101, mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 0, 0));
    run_vec(102, mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h4, 0, 0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
